// File: rtl/instr_controller.sv
// Fetch/decode/execute sequencer driving datapath, PC and memory controls as Moore decodes of the state.
// One state per cycle, no stalls; only the immediate sign extension and the branch decision look at inputs directly.
module instr_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in_ir,
   input  logic [2:0]  status,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  vsel,
   output logic [1:0]  ALUop,
   output logic [1:0]  shift,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5,
   output logic        load_ir,
   output logic        load_pc,
   output logic        reset_pc,
   output logic        load_addr,
   output logic        addr_sel,
   output logic        br_taken,
   output logic [1:0]  mem_cmd,
   output logic        halted
);

   typedef enum logic [4:0] {
      S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B,
      S_EXEC, S_WB, S_ADDR, S_LD_ADDR, S_MEM_RD, S_MEM_WB, S_STR_RD, S_STR_C,
      S_MEM_WR, S_BRANCH, S_HALT
   } state_t;

   state_t state_q, state_d;

   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] rn, rd, rm;
   logic       is_movi, is_movr, is_alu, is_cmp, is_ldr, is_str, is_br, is_halt;
   logic       flag_z, flag_lt, cond_true;

   assign opcode  = in_ir[15:13];
   assign op      = in_ir[12:11];
   assign rn      = in_ir[10:8];
   assign rd      = in_ir[7:5];
   assign rm      = in_ir[2:0];

   assign is_movi = (opcode == 3'b110) && (op == 2'b10);
   assign is_movr = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu  = (opcode == 3'b101);
   assign is_cmp  = is_alu && (op == 2'b01);
   assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
   assign is_str  = (opcode == 3'b100) && (op == 2'b00);
   assign is_br   = (opcode == 3'b001);
   assign is_halt = (opcode == 3'b111);

   assign sximm8  = {{8{in_ir[7]}}, in_ir[7:0]};
   assign sximm5  = {{11{in_ir[4]}}, in_ir[4:0]};

   // Signed less-than after CMP is N xor V
   assign flag_z  = status[0];
   assign flag_lt = status[1] ^ status[2];

   always_comb begin
      cond_true = 1'b0;
      case (rn)
         3'b000:  cond_true = 1'b1;
         3'b001:  cond_true = flag_z;
         3'b010:  cond_true = ~flag_z;
         3'b011:  cond_true = flag_lt;
         3'b100:  cond_true = flag_z | flag_lt;
         default: cond_true = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_RST;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:     state_d = S_IF1;
         S_IF1:     state_d = S_IF2;
         S_IF2:     state_d = S_UPD_PC;
         S_UPD_PC:  state_d = S_DECODE;
         S_DECODE: begin
            if (is_movi)                          state_d = S_WR_IMM;
            else if (is_movr)                     state_d = S_GET_B;
            else if (is_alu || is_ldr || is_str)  state_d = S_GET_A;
            else if (is_br)                       state_d = S_BRANCH;
            else if (is_halt)                     state_d = S_HALT;
            else                                  state_d = S_IF1;
         end
         S_WR_IMM:  state_d = S_IF1;
         S_GET_A:   state_d = is_alu ? S_GET_B : S_ADDR;
         S_GET_B:   state_d = S_EXEC;
         S_EXEC:    state_d = is_cmp ? S_IF1 : S_WB;
         S_WB:      state_d = S_IF1;
         S_ADDR:    state_d = S_LD_ADDR;
         S_LD_ADDR: state_d = is_str ? S_STR_RD : S_MEM_RD;
         S_MEM_RD:  state_d = S_MEM_WB;
         S_MEM_WB:  state_d = S_IF1;
         S_STR_RD:  state_d = S_STR_C;
         S_STR_C:   state_d = S_MEM_WR;
         S_MEM_WR:  state_d = S_IF1;
         S_BRANCH:  state_d = S_IF1;
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_RST;
      endcase
   end

   always_comb begin
      readnum   = 3'd0;
      writenum  = 3'd0;
      write     = 1'b0;
      loada     = 1'b0;
      loadb     = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      vsel      = 2'd0;
      ALUop     = 2'd0;
      shift     = 2'd0;
      load_ir   = 1'b0;
      load_pc   = 1'b0;
      reset_pc  = 1'b0;
      load_addr = 1'b0;
      addr_sel  = 1'b0;
      br_taken  = 1'b0;
      mem_cmd   = 2'b00;
      halted    = 1'b0;
      case (state_q)
         S_RST: begin
            reset_pc = 1'b1;
            load_pc  = 1'b1;
         end
         S_IF1: begin
            addr_sel = 1'b1;
            mem_cmd  = 2'b01;
         end
         S_IF2: begin
            addr_sel = 1'b1;
            mem_cmd  = 2'b01;
            load_ir  = 1'b1;
         end
         S_UPD_PC: load_pc = 1'b1;
         S_WR_IMM: begin
            writenum = rn;
            vsel     = 2'd1;
            write    = 1'b1;
         end
         S_GET_A: begin
            readnum = rn;
            loada   = 1'b1;
         end
         S_GET_B: begin
            readnum = rm;
            loadb   = 1'b1;
         end
         S_EXEC: begin
            ALUop = op;
            shift = in_ir[4:3];
            asel  = is_movr;
            loadc = ~is_cmp;
            loads = is_cmp;
         end
         S_WB: begin
            writenum = rd;
            vsel     = 2'd3;
            write    = 1'b1;
         end
         // Address = Rn + sximm5 with no shift applied
         S_ADDR: begin
            bsel  = 1'b1;
            loadc = 1'b1;
         end
         S_LD_ADDR: load_addr = 1'b1;
         S_MEM_RD:  mem_cmd   = 2'b01;
         S_MEM_WB: begin
            mem_cmd  = 2'b01;
            writenum = rd;
            write    = 1'b1;
         end
         S_STR_RD: begin
            readnum = rd;
            loadb   = 1'b1;
         end
         S_STR_C: begin
            asel  = 1'b1;
            loadc = 1'b1;
         end
         S_MEM_WR: mem_cmd = 2'b10;
         S_BRANCH: begin
            load_pc  = 1'b1;
            br_taken = cond_true;
         end
         S_HALT:   halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_instr_controller.sv
// Bench: each instruction expands into a list of expected per-cycle control vectors, played against the controller.
module tb_instr_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_ir;
   logic [2:0]  status;
   logic [2:0]  readnum, writenum;
   logic        write, loada, loadb, loadc, loads, asel, bsel;
   logic [1:0]  vsel, ALUop, shift;
   logic [15:0] sximm8, sximm5;
   logic        load_ir, load_pc, reset_pc, load_addr, addr_sel, br_taken;
   logic [1:0]  mem_cmd;
   logic        halted;

   instr_controller dut (
      .clk(clk), .reset(reset), .in_ir(in_ir), .status(status),
      .readnum(readnum), .writenum(writenum), .write(write),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .vsel(vsel), .ALUop(ALUop), .shift(shift),
      .sximm8(sximm8), .sximm5(sximm5),
      .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
      .load_addr(load_addr), .addr_sel(addr_sel), .br_taken(br_taken),
      .mem_cmd(mem_cmd), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic [2:0] readnum, writenum;
      logic       write, loada, loadb, loadc, loads, asel, bsel;
      logic [1:0] vsel, aluop, shift;
      logic       load_ir, load_pc, reset_pc, load_addr, addr_sel, is_br;
      logic [1:0] mem_cmd;
      logic       halted;
      logic       rst_in, set_ir, st_rand;
      logic [15:0] ir;
      logic [2:0] st;
   } vec_t;

   vec_t plan[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic last_br = 1'b0;

   function automatic vec_t mk(string nm);
      vec_t v;
      v.nm = nm;
      v.readnum = 0; v.writenum = 0; v.write = 0; v.loada = 0; v.loadb = 0;
      v.loadc = 0; v.loads = 0; v.asel = 0; v.bsel = 0; v.vsel = 0;
      v.aluop = 0; v.shift = 0; v.load_ir = 0; v.load_pc = 0; v.reset_pc = 0;
      v.load_addr = 0; v.addr_sel = 0; v.is_br = 0; v.mem_cmd = 0; v.halted = 0;
      v.rst_in = 0; v.set_ir = 0; v.st_rand = 1; v.ir = 0; v.st = 0;
      return v;
   endfunction

   function automatic vec_t mk_rst();
      vec_t v = mk("RST");
      v.reset_pc = 1; v.load_pc = 1;
      return v;
   endfunction

   // Expected control vectors for one instruction, fetch included
   task automatic plan_instr(input logic [15:0] ir);
      vec_t v;
      logic [2:0] opc, rn, rd, rm;
      logic [1:0] o2;
      opc = ir[15:13]; o2 = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; rm = ir[2:0];
      v = mk("IF1");    v.addr_sel = 1; v.mem_cmd = 1;                plan.push_back(v);
      v = mk("IF2");    v.addr_sel = 1; v.mem_cmd = 1; v.load_ir = 1; plan.push_back(v);
      v = mk("UPD_PC"); v.load_pc = 1; v.set_ir = 1; v.ir = ir;       plan.push_back(v);
      plan.push_back(mk("DECODE"));
      if (opc == 3'b110 && o2 == 2'b10) begin
         v = mk("WR_IMM"); v.writenum = rn; v.vsel = 1; v.write = 1; plan.push_back(v);
      end else if (opc == 3'b101 || (opc == 3'b110 && o2 == 2'b00)) begin
         if (opc == 3'b101) begin
            v = mk("GET_A"); v.readnum = rn; v.loada = 1; plan.push_back(v);
         end
         v = mk("GET_B"); v.readnum = rm; v.loadb = 1; plan.push_back(v);
         v = mk("EXEC"); v.aluop = o2; v.shift = ir[4:3]; v.asel = (opc == 3'b110);
         if (opc == 3'b101 && o2 == 2'b01) v.loads = 1; else v.loadc = 1;
         plan.push_back(v);
         if (!(opc == 3'b101 && o2 == 2'b01)) begin
            v = mk("WB"); v.writenum = rd; v.vsel = 3; v.write = 1; plan.push_back(v);
         end
      end else if ((opc == 3'b011 || opc == 3'b100) && o2 == 2'b00) begin
         v = mk("GET_A");   v.readnum = rn; v.loada = 1; plan.push_back(v);
         v = mk("ADDR");    v.bsel = 1; v.loadc = 1;     plan.push_back(v);
         v = mk("LD_ADDR"); v.load_addr = 1;             plan.push_back(v);
         if (opc == 3'b011) begin
            v = mk("MEM_RD"); v.mem_cmd = 1; plan.push_back(v);
            v = mk("MEM_WB"); v.mem_cmd = 1; v.writenum = rd; v.write = 1; plan.push_back(v);
         end else begin
            v = mk("STR_RD"); v.readnum = rd; v.loadb = 1; plan.push_back(v);
            v = mk("STR_C");  v.asel = 1; v.loadc = 1;     plan.push_back(v);
            v = mk("MEM_WR"); v.mem_cmd = 2;               plan.push_back(v);
         end
      end else if (opc == 3'b001) begin
         v = mk("BRANCH"); v.load_pc = 1; v.is_br = 1; plan.push_back(v);
      end else if (opc == 3'b111) begin
         for (int i = 0; i < 10; i++) begin
            v = mk("HALT"); v.halted = 1; v.rst_in = (i == 9); plan.push_back(v);
         end
         plan.push_back(mk_rst());
      end
   endtask

   // Assert reset during entry k, drop the rest, expect RST next
   task automatic abort_at(input int k);
      vec_t v;
      v = plan[k];
      v.rst_in = 1;
      while (plan.size() > k) void'(plan.pop_back());
      plan.push_back(v);
      plan.push_back(mk_rst());
   endtask

   function automatic logic branch_rule(input logic [2:0] cond, input logic [2:0] st);
      logic z, lt;
      z  = st[0];
      lt = (st[1] != st[2]);
      if (cond == 3'd0) return 1'b1;
      if (cond == 3'd1) return z;
      if (cond == 3'd2) return !z;
      if (cond == 3'd3) return lt;
      if (cond == 3'd4) return z || lt;
      return 1'b0;
   endfunction

   task automatic play();
      vec_t e;
      logic [59:0] got, expv;
      logic [15:0] x8, x5;
      logic        xbr;
      while (plan.size() > 0) begin
         e = plan.pop_front();
         @(posedge clk);
         #1;
         reset  = e.rst_in;
         if (e.set_ir) in_ir = e.ir;
         status = e.st_rand ? 3'($urandom) : e.st;
         @(negedge clk);
         x8  = in_ir[7] ? 16'(in_ir[7:0]) - 16'd256 : 16'(in_ir[7:0]);
         x5  = in_ir[4] ? 16'(in_ir[4:0]) - 16'd32  : 16'(in_ir[4:0]);
         xbr = e.is_br ? branch_rule(in_ir[10:8], status) : 1'b0;
         if (e.is_br) last_br = br_taken;
         got  = {readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel,
                 vsel, ALUop, shift, sximm8, sximm5, load_ir, load_pc, reset_pc,
                 load_addr, addr_sel, br_taken, mem_cmd, halted};
         expv = {e.readnum, e.writenum, e.write, e.loada, e.loadb, e.loadc, e.loads,
                 e.asel, e.bsel, e.vsel, e.aluop, e.shift, x8, x5, e.load_ir,
                 e.load_pc, e.reset_pc, e.load_addr, e.addr_sel, xbr, e.mem_cmd,
                 e.halted};
         vectors++;
         if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (in_ir=%h status=%b t=%0t)",
                     e.nm, got, expv, in_ir, status, $time);
         end
      end
   endtask

   task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   initial begin
      vec_t        v;
      logic [31:0] r;
      logic [15:0] ir;
      reset  = 1'b1;
      in_ir  = 16'h0000;
      status = 3'b000;

      plan.push_back(mk_rst());
      play();

      plan_instr(16'hD007);
      lit("movi_plan_len", plan.size(), 5);
      play();
      lit("movi_sximm8", sximm8, 16'h0007);

      plan_instr(16'hA041);
      lit("add_plan_len", plan.size(), 8);
      play();

      plan_instr(16'hA849);
      lit("cmp_exec_model", {plan[6].loads, plan[6].loadc, plan[6].aluop, plan[6].shift}, 6'b10_0101);
      play();

      plan_instr(16'h6022);
      play();
      lit("ldr_sximm5", sximm5, 16'h0002);
      plan_instr(16'h8022);
      lit("str_memwr_model", plan[9].mem_cmd, 2'b10);
      play();

      plan_instr(16'h21FE);
      v = plan.pop_back(); v.st_rand = 0; v.st = 3'b001; plan.push_back(v);
      play();
      lit("beq_taken", last_br, 1'b1);
      lit("beq_sximm8", sximm8, 16'hFFFE);
      plan_instr(16'h21FE);
      v = plan.pop_back(); v.st_rand = 0; v.st = 3'b000; plan.push_back(v);
      play();
      lit("beq_not_taken", last_br, 1'b0);

      plan_instr(16'hE000);
      play();
      lit("halt_then_rst", {halted, reset_pc, load_pc}, 3'b011);

      plan_instr(16'h8022);
      abort_at(9);
      play();

      for (int n = 0; n < 300; n++) begin
         r  = $urandom;
         ir = r[15:0];
         case ($urandom_range(0, 7))
            0: ir[15:11] = 5'b110_10;
            1: ir[15:11] = 5'b110_00;
            2: ir[15:13] = 3'b101;
            3: ir[15:11] = 5'b011_00;
            4: ir[15:11] = 5'b100_00;
            5: ir[15:13] = 3'b001;
            6: if ($urandom_range(0, 3) != 0) ir[15:13] = 3'b001;
            default: ;
         endcase
         plan_instr(ir);
         if ($urandom_range(0, 7) == 0)
            abort_at($urandom_range(0, plan.size() - 1));
         play();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
